lsu_pipe: RTL and testbench

Parametrised load/store unit that sits between the EX/MEM pipeline boundary and the synchronous data SRAM port of the 5-stage core.
- Generalises the current direct EX-stage SRAM drive:
  - SRAM read latency is configurable.
  - Byte/halfword lane enables are generated internally, so stores are no longer word-only.
  - Load data is aligned and sign/zero extended internally.
  - Misaligned accesses are detected internally.
  - In-flight loads can be cancelled on flush.
- The pipeline stalls on `req_ready`=0 and writes back on `resp_valid`.

---
 rtl/lsu_pipe_pkg.sv | 35 +++
 rtl/lsu_pipe_align.sv | 59 +++++
 rtl/lsu_pipe.sv | 172 +++++++++++++++++
 tb/tb_lsu_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pipe_pkg.sv
// Shared encodings for the load/store unit: memory access types and FSM states.
package lsu_pipe_pkg;

  // Memory access type carried with every EX-stage memory operation
  typedef enum logic [2:0] {
    dm_word          = 3'b000,
    dm_half          = 3'b001,
    dm_half_unsigned = 3'b010,
    dm_byte          = 3'b011,
    dm_byte_unsigned = 3'b100
  } dmtype_e;

  // LSU control states
  typedef enum logic [1:0] {
    LSU_IDLE  = 2'b00,
    LSU_WAIT  = 2'b01,
    LSU_DRAIN = 2'b10
  } lsu_state_e;

  // An access is misaligned when the word/half offset is not naturally aligned,
  // or when the access type is not one of the defined encodings.
  function automatic logic is_misaligned(input logic [2:0] dmtype, input logic [1:0] off);
    logic bad;
    case (dmtype)
      dm_word:          bad = (off != 2'b00);
      dm_half:          bad = off[0];
      dm_half_unsigned: bad = off[0];
      dm_byte:          bad = 1'b0;
      dm_byte_unsigned: bad = 1'b0;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_pipe_align.sv
// Combinational lane logic: store byte enables / data replication / misalign
// detection, and load data alignment with sign or zero extension.
module lsu_align
  import lsu_pipe_pkg::*;
(
  input  logic [2:0]  i_st_dmtype,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata_rep,
  output logic        o_st_misalign,
  input  logic [2:0]  i_ld_dmtype,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shift;

  // Store side: lane enables and lane-replicated write data
  always_comb begin
    o_st_be        = 4'b0000;
    o_st_wdata_rep = i_st_wdata;
    o_st_misalign  = is_misaligned(i_st_dmtype, i_st_off);
    case (i_st_dmtype)
      dm_word: begin
        o_st_be        = 4'b1111;
        o_st_wdata_rep = i_st_wdata;
      end
      dm_half, dm_half_unsigned: begin
        o_st_be        = 4'b0011 << {i_st_off[1], 1'b0};
        o_st_wdata_rep = {2{i_st_wdata[15:0]}};
      end
      dm_byte, dm_byte_unsigned: begin
        o_st_be        = 4'b0001 << i_st_off;
        o_st_wdata_rep = {4{i_st_wdata[7:0]}};
      end
      default: begin
        o_st_be        = 4'b0000;
        o_st_wdata_rep = i_st_wdata;
      end
    endcase
  end

  // Load side: move the addressed lane to bit 0, then extend to 32 bits
  always_comb begin
    w_shift   = i_ld_rdata >> {i_ld_off, 3'b000};
    o_ld_data = w_shift;
    case (i_ld_dmtype)
      dm_word:          o_ld_data = w_shift;
      dm_half:          o_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
      dm_half_unsigned: o_ld_data = {16'h0000, w_shift[15:0]};
      dm_byte:          o_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
      dm_byte_unsigned: o_ld_data = {24'h000000, w_shift[7:0]};
      default:          o_ld_data = w_shift;
    endcase
  end

endmodule

// File: rtl/lsu_pipe.sv
// Load/store unit between the EX/MEM boundary and the synchronous data SRAM.
// Drives the SRAM combinationally in the accept cycle, tracks outstanding loads
// with a latency counter and returns aligned, extended load data.
module lsu_pipe
  import lsu_pipe_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int RD_W        = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_dmtype,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [RD_W-1:0]   i_req_rd,
  input  logic              i_flush,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic [RD_W-1:0]   o_resp_rd,
  output logic              o_misalign,
  output logic [ADDR_W-1:0] o_misalign_addr,
  output logic              o_data_sram_en,
  output logic [3:0]        o_data_sram_we,
  output logic [ADDR_W-1:0] o_data_sram_addr,
  output logic [31:0]       o_data_sram_wdata,
  input  logic [31:0]       i_data_sram_rdata
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  lsu_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [RD_W-1:0]   r_rd;
  logic [2:0]        r_dmtype;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_misalign_addr;

  logic        w_cnt_zero;
  logic        w_ready;
  logic        w_accept;
  logic        w_mis;
  logic        w_mis_acc;
  logic        w_load_acc;
  logic        w_store_acc;
  logic        w_resp;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_ld_data;

  lsu_align u_align (
    .i_st_dmtype    (i_req_dmtype),
    .i_st_off       (i_req_addr[1:0]),
    .i_st_wdata     (i_req_wdata),
    .o_st_be        (w_be),
    .o_st_wdata_rep (w_wdata_rep),
    .o_st_misalign  (w_mis),
    .i_ld_dmtype    (r_dmtype),
    .i_ld_off       (r_off),
    .i_ld_rdata     (i_data_sram_rdata),
    .o_ld_data      (w_ld_data)
  );

  // Handshake and accept classification; flush masks acceptance in its cycle
  always_comb begin
    w_cnt_zero = (r_cnt == CNT_ZERO);
    if (r_state == LSU_IDLE) begin
      w_ready = ~i_flush;
    end else if (r_state == LSU_WAIT) begin
      w_ready = w_cnt_zero & ~i_flush;
    end else begin
      w_ready = 1'b0;
    end
    w_accept    = i_req_valid & w_ready;
    w_mis_acc   = w_accept & w_mis;
    w_load_acc  = w_accept & ~w_mis & ~i_req_we;
    w_store_acc = w_accept & ~w_mis & i_req_we;
    w_resp      = (r_state == LSU_WAIT) & w_cnt_zero & ~i_flush;
  end

  // Output drive: SRAM port in the accept cycle, response in the cnt==0 WAIT cycle
  always_comb begin
    o_req_ready       = w_ready;
    o_misalign        = w_mis_acc;
    o_misalign_addr   = r_misalign_addr;
    o_data_sram_en    = w_load_acc | w_store_acc;
    o_data_sram_we    = w_store_acc ? w_be : 4'b0000;
    if (w_load_acc | w_store_acc) begin
      o_data_sram_addr  = {i_req_addr[ADDR_W-1:2], 2'b00};
      o_data_sram_wdata = w_wdata_rep;
    end else begin
      o_data_sram_addr  = {ADDR_W{1'b0}};
      o_data_sram_wdata = 32'h0000_0000;
    end
    if (w_resp) begin
      o_resp_valid = 1'b1;
      o_resp_rdata = w_ld_data;
      o_resp_rd    = r_rd;
    end else begin
      o_resp_valid = 1'b0;
      o_resp_rdata = 32'h0000_0000;
      o_resp_rd    = {RD_W{1'b0}};
    end
  end

  // Control FSM and latency counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LSU_IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (w_load_acc) begin
            r_state <= LSU_WAIT;
            r_cnt   <= CNT_START;
          end
        end
        LSU_WAIT: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CNT_ONE;
            if (i_flush) begin
              r_state <= LSU_DRAIN;
            end
          end else if (w_load_acc) begin
            r_state <= LSU_WAIT;
            r_cnt   <= CNT_START;
          end else begin
            r_state <= LSU_IDLE;
          end
        end
        LSU_DRAIN: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_state <= LSU_IDLE;
          end
        end
        default: begin
          r_state <= LSU_IDLE;
          r_cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Capture load context on accept and the faulting address on a misaligned accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd            <= {RD_W{1'b0}};
      r_dmtype        <= 3'b000;
      r_off           <= 2'b00;
      r_misalign_addr <= {ADDR_W{1'b0}};
    end else begin
      if (w_load_acc) begin
        r_rd     <= i_req_rd;
        r_dmtype <= i_req_dmtype;
        r_off    <= i_req_addr[1:0];
      end
      if (w_mis_acc) begin
        r_misalign_addr <= i_req_addr;
      end
    end
  end

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe: instance A uses MEM_LATENCY=1, instance B uses 3.
module tb_lsu_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A (latency 1)
  logic        a_valid, a_we, a_flush, a_ready, a_rv, a_mis, a_en;
  logic [2:0]  a_dm;
  logic [31:0] a_addr, a_wdata, a_rdata, a_resp, a_mis_addr, a_saddr, a_swd;
  logic [4:0]  a_rd, a_resp_rd;
  logic [3:0]  a_swe;

  // Instance B (latency 3)
  logic        b_valid, b_we, b_flush, b_ready, b_rv, b_mis, b_en;
  logic [2:0]  b_dm;
  logic [31:0] b_addr, b_wdata, b_rdata, b_resp, b_mis_addr, b_saddr, b_swd;
  logic [4:0]  b_rd, b_resp_rd;
  logic [3:0]  b_swe;

  int n_chk  = 0;
  int n_pass = 0;

  lsu_pipe #(.ADDR_W(32), .MEM_LATENCY(1), .RD_W(5)) u_dut_a (
    .clk(clk), .reset(reset),
    .i_req_valid(a_valid), .o_req_ready(a_ready), .i_req_we(a_we),
    .i_req_dmtype(a_dm), .i_req_addr(a_addr), .i_req_wdata(a_wdata),
    .i_req_rd(a_rd), .i_flush(a_flush),
    .o_resp_valid(a_rv), .o_resp_rdata(a_resp), .o_resp_rd(a_resp_rd),
    .o_misalign(a_mis), .o_misalign_addr(a_mis_addr),
    .o_data_sram_en(a_en), .o_data_sram_we(a_swe), .o_data_sram_addr(a_saddr),
    .o_data_sram_wdata(a_swd), .i_data_sram_rdata(a_rdata)
  );

  lsu_pipe #(.ADDR_W(32), .MEM_LATENCY(3), .RD_W(5)) u_dut_b (
    .clk(clk), .reset(reset),
    .i_req_valid(b_valid), .o_req_ready(b_ready), .i_req_we(b_we),
    .i_req_dmtype(b_dm), .i_req_addr(b_addr), .i_req_wdata(b_wdata),
    .i_req_rd(b_rd), .i_flush(b_flush),
    .o_resp_valid(b_rv), .o_resp_rdata(b_resp), .o_resp_rd(b_resp_rd),
    .o_misalign(b_mis), .o_misalign_addr(b_mis_addr),
    .o_data_sram_en(b_en), .o_data_sram_we(b_swe), .o_data_sram_addr(b_saddr),
    .o_data_sram_wdata(b_swd), .i_data_sram_rdata(b_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_a(input logic v, input logic we, input logic [2:0] dm,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    a_valid = v; a_we = we; a_dm = dm; a_addr = addr; a_wdata = wd; a_rd = rd;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [2:0] dm,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    b_valid = v; b_we = we; b_dm = dm; b_addr = addr; b_wdata = wd; b_rd = rd;
  endtask

  initial begin
    reset = 1'b1;
    a_flush = 1'b0; b_flush = 1'b0;
    a_rdata = 32'h0; b_rdata = 32'h0;
    set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    set_b(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    #2;
    chk("rst_a_ready", {31'd0, a_ready}, 32'd1);
    chk("rst_a_rv", {31'd0, a_rv}, 32'd0);
    chk("rst_a_en", {31'd0, a_en}, 32'd0);
    chk("rst_a_misaddr", a_mis_addr, 32'h0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd1);
    chk("rst_b_mis", {31'd0, b_mis}, 32'd0);

    step();
    reset = 1'b0;

    // Store byte then store half back to back (latency 1)
    set_a(1'b1, 1'b1, 3'b011, 32'h103, 32'h0000_00A5, 5'd0);
    mid();
    chk("sb_we", {28'd0, a_swe}, 32'h8);
    chk("sb_addr", a_saddr, 32'h100);
    chk("sb_wdata", a_swd, 32'hA5A5_A5A5);
    chk("sb_ready", {31'd0, a_ready}, 32'd1);
    chk("sb_en", {31'd0, a_en}, 32'd1);
    step();
    set_a(1'b1, 1'b1, 3'b001, 32'h102, 32'h0000_1234, 5'd0);
    mid();
    chk("sh_we", {28'd0, a_swe}, 32'hC);
    chk("sh_wdata", a_swd, 32'h1234_1234);
    chk("sh_ready", {31'd0, a_ready}, 32'd1);

    // Back-to-back loads at latency 1: lh, lhu, lb, lb
    step();
    set_a(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd7);
    a_rdata = 32'h8001_7F00;
    mid();
    chk("lh_en", {31'd0, a_en}, 32'd1);
    chk("lh_we", {28'd0, a_swe}, 32'h0);
    chk("lh_rv_T", {31'd0, a_rv}, 32'd0);
    step();
    set_a(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd8);
    mid();
    chk("lh_rv", {31'd0, a_rv}, 32'd1);
    chk("lh_data", a_resp, 32'hFFFF_8001);
    chk("lh_rd", {27'd0, a_resp_rd}, 32'd7);
    chk("lh_ready", {31'd0, a_ready}, 32'd1);
    step();
    set_a(1'b1, 1'b0, 3'b011, 32'h101, 32'h0, 5'd9);
    mid();
    chk("lhu_data", a_resp, 32'h0000_8001);
    chk("lhu_rd", {27'd0, a_resp_rd}, 32'd8);
    step();
    set_a(1'b1, 1'b0, 3'b011, 32'h103, 32'h0, 5'd10);
    mid();
    chk("lb1_data", a_resp, 32'h0000_007F);
    step();
    set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    mid();
    chk("lb3_data", a_resp, 32'hFFFF_FF80);
    chk("lb3_rd", {27'd0, a_resp_rd}, 32'd10);
    step();
    mid();
    chk("a_idle_rv", {31'd0, a_rv}, 32'd0);

    // Misaligned word load, then undefined dmtype store
    step();
    set_a(1'b1, 1'b0, 3'b000, 32'h206, 32'h0, 5'd3);
    mid();
    chk("mis_pulse", {31'd0, a_mis}, 32'd1);
    chk("mis_en", {31'd0, a_en}, 32'd0);
    chk("mis_we", {28'd0, a_swe}, 32'h0);
    step();
    set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    mid();
    chk("mis_addr", a_mis_addr, 32'h206);
    chk("mis_clear", {31'd0, a_mis}, 32'd0);
    chk("mis_no_rv", {31'd0, a_rv}, 32'd0);
    step();
    set_a(1'b1, 1'b1, 3'b101, 32'h300, 32'h55, 5'd0);
    mid();
    chk("bad_dm_mis", {31'd0, a_mis}, 32'd1);
    chk("bad_dm_we", {28'd0, a_swe}, 32'h0);
    step();
    set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    mid();
    chk("bad_dm_addr", a_mis_addr, 32'h300);

    // Latency 3: two lw back to back
    step();
    set_b(1'b1, 1'b0, 3'b000, 32'h40, 32'h0, 5'd3);
    b_rdata = 32'h1111_1111;
    mid();
    chk("l3_T_ready", {31'd0, b_ready}, 32'd1);
    chk("l3_T_en", {31'd0, b_en}, 32'd1);
    step();
    set_b(1'b1, 1'b0, 3'b000, 32'h44, 32'h0, 5'd4);
    mid();
    chk("l3_T1_ready", {31'd0, b_ready}, 32'd0);
    chk("l3_T1_rv", {31'd0, b_rv}, 32'd0);
    chk("l3_T1_en", {31'd0, b_en}, 32'd0);
    step();
    mid();
    chk("l3_T2_ready", {31'd0, b_ready}, 32'd0);
    step();
    mid();
    chk("l3_T3_rv", {31'd0, b_rv}, 32'd1);
    chk("l3_T3_data", b_resp, 32'h1111_1111);
    chk("l3_T3_rd", {27'd0, b_resp_rd}, 32'd3);
    chk("l3_T3_ready", {31'd0, b_ready}, 32'd1);
    chk("l3_T3_en", {31'd0, b_en}, 32'd1);
    step();
    set_b(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    b_rdata = 32'h2222_2222;
    mid();
    chk("l3_T4_ready", {31'd0, b_ready}, 32'd0);
    chk("l3_T4_rv", {31'd0, b_rv}, 32'd0);
    step();
    mid();
    chk("l3_T5_rv", {31'd0, b_rv}, 32'd0);
    step();
    mid();
    chk("l3_T6_rv", {31'd0, b_rv}, 32'd1);
    chk("l3_T6_data", b_resp, 32'h2222_2222);
    chk("l3_T6_rd", {27'd0, b_resp_rd}, 32'd4);
    step();
    mid();
    chk("l3_T7_rv", {31'd0, b_rv}, 32'd0);
    chk("l3_T7_ready", {31'd0, b_ready}, 32'd1);

    // Flush one cycle after a latency-3 load
    step();
    set_b(1'b1, 1'b0, 3'b000, 32'h80, 32'h0, 5'd5);
    mid();
    chk("fl_T_ready", {31'd0, b_ready}, 32'd1);
    step();
    set_b(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    b_flush = 1'b1;
    mid();
    chk("fl_T1_ready", {31'd0, b_ready}, 32'd0);
    step();
    b_flush = 1'b0;
    mid();
    chk("fl_T2_ready", {31'd0, b_ready}, 32'd0);
    step();
    mid();
    chk("fl_T3_rv", {31'd0, b_rv}, 32'd0);
    chk("fl_T3_ready", {31'd0, b_ready}, 32'd0);
    step();
    mid();
    chk("fl_T4_ready", {31'd0, b_ready}, 32'd1);

    // Flush in IDLE masks a concurrent request but leaves the unit idle
    step();
    b_flush = 1'b1;
    set_b(1'b1, 1'b0, 3'b000, 32'h80, 32'h0, 5'd5);
    mid();
    chk("fl_idle_ready", {31'd0, b_ready}, 32'd0);
    chk("fl_idle_en", {31'd0, b_en}, 32'd0);
    step();
    b_flush = 1'b0;
    set_b(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    mid();
    chk("fl_idle_after", {31'd0, b_ready}, 32'd1);

    // Asynchronous reset while a load waits
    step();
    set_b(1'b1, 1'b0, 3'b000, 32'h40, 32'h0, 5'd6);
    mid();
    step();
    set_b(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    mid();
    chk("rw_wait_ready", {31'd0, b_ready}, 32'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("rw_ready", {31'd0, b_ready}, 32'd1);
    chk("rw_rv", {31'd0, b_rv}, 32'd0);
    step();
    reset = 1'b0;
    set_b(1'b1, 1'b0, 3'b000, 32'h48, 32'h0, 5'd7);
    b_rdata = 32'h3333_3333;
    mid();
    chk("rw_R_en", {31'd0, b_en}, 32'd1);
    step();
    set_b(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    mid();
    chk("rw_R1_rv", {31'd0, b_rv}, 32'd0);
    step();
    mid();
    chk("rw_R2_rv", {31'd0, b_rv}, 32'd0);
    step();
    mid();
    chk("rw_R3_rv", {31'd0, b_rv}, 32'd1);
    chk("rw_R3_data", b_resp, 32'h3333_3333);
    chk("rw_R3_rd", {27'd0, b_resp_rd}, 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
